// File: rtl/conv2d_seq.sv
// conv2d_seq: layer sequencer for a 2-D convolution engine.
// For every (output channel, input channel) pair it issues a weight
// prefetch, waits for the datapath, issues a pass enable and waits for
// pass completion. Passes run input channel inner, output channel outer.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   start                         single-cycle layer start (ignored when busy)
//   cfg_xbase/ybase/wbase [AW]    input / output / weight base byte addresses
//   cfg_width, cfg_height [9]     plane dimensions in pixels
//   cfg_n_in, cfg_n_out [8]       input / output channel counts
//   pref_done, pass_done          completion pulses from the datapath
//   param_prefetch, param_ena     2-cycle request pulses to the read-memory block
//   param_waddr/xaddr/yaddr [AW]  per-pass weight / input / output addresses
//   param_length_w [8]            weights per pass (KS*KS)
//   param_width_in [9]            latched plane width
//   param_length_in/out [18]      latched plane size (width*height, truncated)
//   busy, done                    layer active / one-cycle completion pulse
//   cur_ic, cur_oc [8]            current channel indices
module conv2d_seq #(
  parameter int unsigned AW = 32,
  parameter int unsigned KS = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] cfg_xbase,
  input  logic [AW-1:0] cfg_ybase,
  input  logic [AW-1:0] cfg_wbase,
  input  logic [8:0]    cfg_width,
  input  logic [8:0]    cfg_height,
  input  logic [7:0]    cfg_n_in,
  input  logic [7:0]    cfg_n_out,
  input  logic          pref_done,
  input  logic          pass_done,
  output logic          param_prefetch,
  output logic          param_ena,
  output logic [AW-1:0] param_waddr,
  output logic [AW-1:0] param_xaddr,
  output logic [AW-1:0] param_yaddr,
  output logic [7:0]    param_length_w,
  output logic [8:0]    param_width_in,
  output logic [17:0]   param_length_in,
  output logic [17:0]   param_length_out,
  output logic          busy,
  output logic          done,
  output logic [7:0]    cur_ic,
  output logic [7:0]    cur_oc
);

  typedef enum logic [2:0] {IDLE, PREF, PWAIT, ENA, XWAIT, NEXT, FIN} state_t;

  localparam logic [AW-1:0] WSTEP = AW'(KS * KS * 4);

  state_t        state;
  logic          ph;        // second cycle of a 2-cycle pulse phase
  logic [7:0]    n_in;
  logic [7:0]    n_out;
  logic [AW-1:0] xbase;
  logic [AW-1:0] pstep;     // plane size in bytes (plane*4)
  logic [17:0]   plane_c;
  logic          ic_last;
  logic          oc_last;

  assign plane_c        = 18'(cfg_width) * 18'(cfg_height);
  assign param_length_w = 8'(KS * KS);
  assign ic_last        = (cur_ic == n_in - 8'd1);
  assign oc_last        = (cur_oc == n_out - 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      ph               <= 1'b0;
      n_in             <= '0;
      n_out            <= '0;
      xbase            <= '0;
      pstep            <= '0;
      param_prefetch   <= 1'b0;
      param_ena        <= 1'b0;
      param_waddr      <= '0;
      param_xaddr      <= '0;
      param_yaddr      <= '0;
      param_width_in   <= '0;
      param_length_in  <= '0;
      param_length_out <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      cur_ic           <= '0;
      cur_oc           <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n_in             <= cfg_n_in;
            n_out            <= cfg_n_out;
            xbase            <= cfg_xbase;
            pstep            <= AW'({plane_c, 2'b00});
            param_xaddr      <= cfg_xbase;
            param_yaddr      <= cfg_ybase;
            param_waddr      <= cfg_wbase;
            param_width_in   <= cfg_width;
            param_length_in  <= plane_c;
            param_length_out <= plane_c;
            cur_ic           <= '0;
            cur_oc           <= '0;
            busy             <= 1'b1;
            ph               <= 1'b0;
            if (cfg_n_in == 8'd0 || cfg_n_out == 8'd0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state          <= PREF;
              param_prefetch <= 1'b1;
            end
          end
        end
        PREF: begin
          if (ph) begin
            state          <= PWAIT;
            param_prefetch <= 1'b0;
            ph             <= 1'b0;
          end else begin
            ph <= 1'b1;
          end
        end
        PWAIT: begin
          if (pref_done) begin
            state     <= ENA;
            param_ena <= 1'b1;
          end
        end
        ENA: begin
          if (ph) begin
            state     <= XWAIT;
            param_ena <= 1'b0;
            ph        <= 1'b0;
          end else begin
            ph <= 1'b1;
          end
        end
        XWAIT: begin
          if (pass_done) state <= NEXT;
        end
        NEXT: begin
          if (ic_last && oc_last) begin
            state <= FIN;
            done  <= 1'b1;
          end else begin
            // Weight index oc*n_in+ic always advances by one pass, including
            // on the oc wrap, so the weight address steps uniformly.
            param_waddr <= param_waddr + WSTEP;
            if (ic_last) begin
              cur_ic      <= '0;
              cur_oc      <= cur_oc + 8'd1;
              param_xaddr <= xbase;
              param_yaddr <= param_yaddr + pstep;
            end else begin
              cur_ic      <= cur_ic + 8'd1;
              param_xaddr <= param_xaddr + pstep;
            end
            state          <= PREF;
            param_prefetch <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_seq.sv
// Directed self-checking bench for conv2d_seq.
module tb_conv2d_seq;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] cfg_xbase, cfg_ybase, cfg_wbase;
  logic [8:0]    cfg_width, cfg_height;
  logic [7:0]    cfg_n_in, cfg_n_out;
  logic          pref_done, pass_done;
  logic          resp_pref, resp_pass, inj_pass;
  logic          param_prefetch, param_ena;
  logic [AW-1:0] param_waddr, param_xaddr, param_yaddr;
  logic [7:0]    param_length_w;
  logic [8:0]    param_width_in;
  logic [17:0]   param_length_in, param_length_out;
  logic          busy, done;
  logic [7:0]    cur_ic, cur_oc;

  assign pref_done = resp_pref;
  assign pass_done = resp_pass | inj_pass;

  conv2d_seq #(.AW(AW), .KS(3)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_xbase(cfg_xbase), .cfg_ybase(cfg_ybase), .cfg_wbase(cfg_wbase),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_n_in(cfg_n_in), .cfg_n_out(cfg_n_out),
    .pref_done(pref_done), .pass_done(pass_done),
    .param_prefetch(param_prefetch), .param_ena(param_ena),
    .param_waddr(param_waddr), .param_xaddr(param_xaddr), .param_yaddr(param_yaddr),
    .param_length_w(param_length_w), .param_width_in(param_width_in),
    .param_length_in(param_length_in), .param_length_out(param_length_out),
    .busy(busy), .done(done), .cur_ic(cur_ic), .cur_oc(cur_oc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Datapath responder: pulses pref_done / pass_done a set number of
  // cycles after the matching request pulse ends.
  int pref_delay = 0;
  int pass_delay = 0;
  initial begin : responder
    logic pp, pe, pw, xw;
    int pc, xc;
    resp_pref = 0; resp_pass = 0;
    pp = 0; pe = 0; pw = 0; xw = 0; pc = 0; xc = 0;
    forever begin
      @(negedge clk);
      resp_pref = 0; resp_pass = 0;
      if (rst) begin
        pw = 0; xw = 0;
      end else begin
        if (pp && !param_prefetch) begin pw = 1; pc = pref_delay; end
        if (pe && !param_ena)      begin xw = 1; xc = pass_delay; end
        if (pw) begin
          if (pc == 0) begin resp_pref = 1; pw = 0; end else pc--;
        end
        if (xw) begin
          if (xc == 0) begin resp_pass = 1; xw = 0; end else xc--;
        end
      end
      pp = param_prefetch; pe = param_ena;
    end
  end

  // Monitor: records addresses/indices at each prefetch rise, pulse widths,
  // address stability at ena rise, and done pulses.
  logic [AW-1:0] xq[$], yq[$], wq[$];
  logic [7:0]    icq[$], ocq[$];
  int pf_rises, en_rises, done_cnt, bad_w, unstable;
  initial begin : monitor
    logic m_pf, m_en;
    int pf_len, en_len;
    m_pf = 0; m_en = 0; pf_len = 0; en_len = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_pf = 0; m_en = 0; pf_len = 0; en_len = 0;
      end else begin
        if (param_prefetch) begin
          if (!m_pf) begin
            pf_rises++; pf_len = 0;
            xq.push_back(param_xaddr); yq.push_back(param_yaddr); wq.push_back(param_waddr);
            icq.push_back(cur_ic); ocq.push_back(cur_oc);
          end
          pf_len++;
        end else if (m_pf && pf_len != 2) bad_w++;
        if (param_ena) begin
          if (!m_en) begin
            en_rises++; en_len = 0;
            if (xq.size() > 0 && (param_xaddr !== xq[$] || param_yaddr !== yq[$] || param_waddr !== wq[$]))
              unstable++;
          end
          en_len++;
        end else if (m_en && en_len != 2) bad_w++;
        if (done) done_cnt++;
        m_pf = param_prefetch; m_en = param_ena;
      end
    end
  end

  task automatic clear_mon();
    xq.delete(); yq.delete(); wq.delete(); icq.delete(); ocq.delete();
    pf_rises = 0; en_rises = 0; done_cnt = 0; bad_w = 0; unstable = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [AW-1:0] xb, yb, wb, input logic [8:0] w, h,
                          input logic [7:0] ni, no);
    cfg_xbase = xb; cfg_ybase = yb; cfg_wbase = wb;
    cfg_width = w; cfg_height = h; cfg_n_in = ni; cfg_n_out = no;
    start = 1;
    tick();
    start = 0;
  endtask

  function automatic logic sel(input int which);
    case (which)
      0:       return param_prefetch;
      1:       return param_ena;
      default: return done;
    endcase
  endfunction

  task automatic wait_for(input int which, input logic v, input int limit, input string tag);
    int n = 0;
    while (sel(which) !== v && n < limit) begin tick(); n++; end
    if (sel(which) !== v) check(tag, 64'(sel(which)), 64'(v));
  endtask

  initial begin
    rst = 1; start = 0; inj_pass = 0;
    cfg_xbase = '0; cfg_ybase = '0; cfg_wbase = '0;
    cfg_width = '0; cfg_height = '0; cfg_n_in = '0; cfg_n_out = '0;
    clear_mon();
    repeat (3) tick();

    // Reset state
    check("rst_ctrl", {60'd0, busy, done, param_prefetch, param_ena}, 64'd0);
    check("rst_idx", {48'd0, cur_ic, cur_oc}, 64'd0);
    check("rst_xy", {param_xaddr, param_yaddr}, 64'd0);
    check("rst_w", 64'(param_waddr), 64'd0);
    check("rst_len", {19'd0, param_width_in, param_length_in, param_length_out}, 64'd0);
    check("len_w", 64'(param_length_w), 64'd9);
    rst = 0;
    tick();

    // Two input channels, one output channel, immediate responses
    clear_mon(); pref_delay = 0; pass_delay = 0;
    do_start(32'h1000, 32'h2000, 32'h3000, 9'd4, 9'd4, 8'd2, 8'd1);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_len", {28'd0, param_length_in, param_length_out}, {28'd0, 18'd16, 18'd16});
    check("t1_width", 64'(param_width_in), 64'd4);
    wait_for(2, 1'b1, 200, "t1_done_timeout");
    check("t1_final_idx", {48'd0, cur_ic, cur_oc}, {48'd0, 8'd1, 8'd0});
    tick();
    check("t1_idle", 64'(busy), 64'd0);
    check("t1_passes", {pf_rises, en_rises}, {32'd2, 32'd2});
    if (xq.size() == 2) begin
      check("t1_x", {xq[0], xq[1]}, {32'h1000, 32'h1040});
      check("t1_y", {yq[0], yq[1]}, {32'h2000, 32'h2000});
      check("t1_w", {wq[0], wq[1]}, {32'h3000, 32'h3024});
    end
    check("t1_done_cnt", 64'(done_cnt), 64'd1);
    check("t1_widths", {bad_w, unstable}, 64'd0);

    // Zero input channels: straight to FIN
    clear_mon();
    do_start(32'h10, 32'h20, 32'h30, 9'd4, 9'd4, 8'd0, 8'd3);
    check("t2_done_now", {62'd0, done, busy}, {62'd0, 1'b1, 1'b1});
    tick();
    check("t2_done_drop", {62'd0, done, busy}, 64'd0);
    repeat (3) tick();
    check("t2_no_pulses", {pf_rises, en_rises}, 64'd0);
    check("t2_done_cnt", 64'(done_cnt), 64'd1);

    // Stray pass_done in PWAIT and start in XWAIT are ignored
    clear_mon(); pref_delay = 5; pass_delay = 5;
    do_start(32'h4000, 32'h5000, 32'h6000, 9'd8, 9'd2, 8'd1, 8'd1);
    wait_for(0, 1'b0, 20, "t3_pwait_timeout");
    inj_pass = 1;
    tick();
    inj_pass = 0;
    check("t3_pwait_hold", {61'd0, busy, param_ena, param_prefetch}, {61'd0, 1'b1, 1'b0, 1'b0});
    wait_for(1, 1'b1, 20, "t3_ena_timeout");
    wait_for(1, 1'b0, 20, "t3_xwait_timeout");
    cfg_xbase = 32'h9999_0000; cfg_width = 9'd100; cfg_n_in = 8'd7;
    start = 1;
    tick();
    start = 0;
    check("t3_xwait_hold", {param_xaddr, 14'd0, param_length_in}, {32'h4000, 14'd0, 18'd16});
    check("t3_xwait_idx", {47'd0, busy, cur_ic, cur_oc}, {47'd0, 1'b1, 16'd0});
    wait_for(2, 1'b1, 200, "t3_done_timeout");
    tick();
    check("t3_passes", {pf_rises, done_cnt}, {32'd1, 32'd1});

    // 3x2 channels, slow pass completion: order and pulse widths
    clear_mon(); pref_delay = 0; pass_delay = 50;
    do_start(32'h100, 32'h8000, 32'h40, 9'd2, 9'd3, 8'd3, 8'd2);
    wait_for(2, 1'b1, 1000, "t4_done_timeout");
    tick();
    check("t4_passes", {pf_rises, en_rises}, {32'd6, 32'd6});
    if (xq.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        logic [31:0] ic, oc;
        ic = 32'(k % 3); oc = 32'(k / 3);
        check($sformatf("t4_idx%0d", k), {48'd0, icq[k], ocq[k]}, {48'd0, ic[7:0], oc[7:0]});
        check($sformatf("t4_xy%0d", k), {xq[k], yq[k]}, {32'h100 + ic * 24, 32'h8000 + oc * 24});
        check($sformatf("t4_w%0d", k), 64'(wq[k]), 64'(32'h40 + (oc * 3 + ic) * 36));
      end
    end
    check("t4_widths", {bad_w, unstable}, 64'd0);
    check("t4_done_cnt", 64'(done_cnt), 64'd1);

    // Reset during ENA aborts immediately; a new layer then runs fully
    clear_mon(); pref_delay = 0; pass_delay = 0;
    do_start(32'h1000, 32'h2000, 32'h3000, 9'd4, 9'd4, 8'd2, 8'd2);
    wait_for(1, 1'b1, 20, "t5_ena_timeout");
    rst = 1;
    #1;
    check("t5_rst_ctrl", {60'd0, busy, done, param_prefetch, param_ena}, 64'd0);
    check("t5_rst_addr", {param_xaddr, param_waddr}, 64'd0);
    check("t5_rst_len", {28'd0, param_length_in, param_length_out}, 64'd0);
    tick();
    rst = 0;
    clear_mon();
    repeat (5) tick();
    check("t5_no_pulses", {pf_rises, en_rises}, 64'd0);
    do_start(32'h500, 32'h600, 32'h700, 9'd3, 9'd3, 8'd1, 8'd1);
    wait_for(2, 1'b1, 200, "t5_done_timeout");
    tick();
    check("t5_passes", {pf_rises, done_cnt}, {32'd1, 32'd1});
    if (xq.size() == 1) check("t5_addr", {xq[0], wq[0]}, {32'h500, 32'h700});

    // Maximum plane truncated to 18 bits
    clear_mon();
    do_start(32'h0, 32'h0, 32'h0, 9'd511, 9'd511, 8'd1, 8'd1);
    check("t6_len", {28'd0, param_length_in, param_length_out}, {28'd0, 18'h3FC01, 18'h3FC01});
    check("t6_width", 64'(param_width_in), 64'd511);
    wait_for(2, 1'b1, 200, "t6_done_timeout");
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
